// File: rtl/an_code_pkg.sv
// rtl/an_code_pkg.sv - shared AN-code constants and frame encoder state type
package an_code_pkg;

   localparam int A        = 37;
   localparam int DW       = 13;
   localparam int CW       = 18;
   localparam int NW       = 36;
   // Largest data word whose product with A still fits in CW bits
   localparam int MAX_DATA = ((1 << CW) - 1) / A;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } enc_state_t;

endpackage

// File: rtl/an_mul_const.sv
// rtl/an_mul_const.sv - combinational AN-code constant multiply with range check
module an_mul_const #(
   parameter int A        = 37,
   parameter int DW       = 13,
   parameter int CW       = 18,
   parameter int MAX_DATA = 7084
)(
   input  logic [DW-1:0] d,
   output logic [CW-1:0] code,
   output logic          out_of_range
);

   // Enough shift positions to cover every set bit of the multiplier
   localparam int AW = $clog2(A + 1);

   logic [CW-1:0] prod;

   // Shift-add over the set bits of A; in-range products always fit CW bits,
   // so truncation only ever affects words that are zeroed anyway
   always_comb begin
      prod = '0;
      for (int i = 0; i < AW; i++) begin
         if (A[i]) prod = prod + (CW'(d) << i);
      end
      out_of_range = (32'(d) > 32'(MAX_DATA));
      code         = out_of_range ? '0 : prod;
   end

endmodule

// File: rtl/an_enc_frame_6x6.sv
// rtl/an_enc_frame_6x6.sv - AN-code frame encoder filling a 6x6 codeword buffer; AN_ENC_ERR_INJ_EN adds error injection
module an_enc_frame_6x6 #(
   parameter int A  = an_code_pkg::A,
   parameter int DW = an_code_pkg::DW,
   parameter int CW = an_code_pkg::CW,
   parameter int NW = an_code_pkg::NW
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [DW-1:0]    in_data,
   output logic             in_ready,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic [NW*CW-1:0] frame_data,
   output logic             range_err,
`ifdef AN_ENC_ERR_INJ_EN
   input  logic             inj_en,
   input  logic [5:0]       inj_idx,
   input  logic [CW-1:0]    inj_mask,
`endif
   input  logic             err_clr
);

   import an_code_pkg::*;

   localparam int CNTW  = $clog2(NW);
   localparam int LIMIT = ((1 << CW) - 1) / A;

   enc_state_t      state;
   logic [CNTW-1:0] cnt;
   logic [CW-1:0]   slot   [NW];
   logic [CW-1:0]   slot_d [NW];
   logic [CW-1:0]   code;
   logic            oor;
   logic            accept;
   logic            last;
   logic            take;

   assign accept = in_valid && in_ready;
   assign last   = accept && (cnt == CNTW'(NW - 1));
   assign take   = frame_valid && frame_ready;

   an_mul_const #(
      .A        (A),
      .DW       (DW),
      .CW       (CW),
      .MAX_DATA (LIMIT)
   ) u_mul (
      .d            (in_data),
      .code         (code),
      .out_of_range (oor)
   );

   // Fill/hold handshake: in_ready and frame_valid are registered; the take
   // cycle never accepts a word, giving a one-cycle handoff between frames
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FILL;
         cnt         <= '0;
         in_ready    <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               in_ready <= 1'b1;
               if (last) begin
                  cnt         <= '0;
                  state       <= HOLD;
                  in_ready    <= 1'b0;
                  frame_valid <= 1'b1;
               end else if (accept) begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (take) begin
                  state       <= FILL;
                  frame_valid <= 1'b0;
                  in_ready    <= 1'b1;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   // Next buffer contents: accepted slot gets its codeword, optional fault
   // is applied on the completing accept so it is in place when frame_valid rises
   always_comb begin
      for (int k = 0; k < NW; k++) begin
         slot_d[k] = slot[k];
         if (accept && (cnt == CNTW'(k))) slot_d[k] = code;
`ifdef AN_ENC_ERR_INJ_EN
         if (last && inj_en && (inj_idx == 6'(k))) slot_d[k] = slot_d[k] ^ inj_mask;
`endif
      end
   end

   // Codeword buffer; untouched slots keep prior-frame values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NW; k++) slot[k] <= '0;
      end else begin
         slot <= slot_d;
      end
   end

   // Sticky range error; a new error in the clear cycle wins over err_clr
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         range_err <= 1'b0;
      end else if (accept && oor) begin
         range_err <= 1'b1;
      end else if (err_clr) begin
         range_err <= 1'b0;
      end
   end

   for (genvar k = 0; k < NW; k++) begin : g_out
      assign frame_data[k*CW +: CW] = slot[k];
   end

endmodule

// File: tb/tb_an_enc_frame_6x6.sv
// tb/tb_an_enc_frame_6x6.sv - randomized self-checking bench for an_enc_frame_6x6; AN_ENC_ERR_INJ_EN adds the injection test
`timescale 1ns/1ps
module tb_an_enc_frame_6x6;

   localparam int A    = 37;
   localparam int DW   = 13;
   localparam int CW   = 18;
   localparam int NW   = 36;
   localparam int MAXD = 7084;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [DW-1:0]    in_data;
   logic             in_ready;
   logic             frame_valid;
   logic             frame_ready;
   logic [NW*CW-1:0] frame_data;
   logic             range_err;
   logic             err_clr;
`ifdef AN_ENC_ERR_INJ_EN
   logic             inj_en;
   logic [5:0]       inj_idx;
   logic [CW-1:0]    inj_mask;
`endif

   int vectors     = 0;
   int miscompares = 0;
   logic [DW-1:0] words [NW];

   always #5 clk = ~clk;

   an_enc_frame_6x6 dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_data  (frame_data),
      .range_err   (range_err),
`ifdef AN_ENC_ERR_INJ_EN
      .inj_en      (inj_en),
      .inj_idx     (inj_idx),
      .inj_mask    (inj_mask),
`endif
      .err_clr     (err_clr)
   );

   // Reference codeword: plain product, zero when it would not fit
   function automatic logic [CW-1:0] ref_code(input logic [DW-1:0] d);
      if (int'(d) <= MAXD) return CW'(int'(d) * A);
      return '0;
   endfunction

   function automatic logic [CW-1:0] word_at(input int k);
      return frame_data[k*CW +: CW];
   endfunction

   // Offers words[first +: num], retrying stalled words; returns at #1 after the last accepting edge
   task automatic fill(input int first, input int num, input bit gaps, output bit ok);
      int n = 0;
      int guard = 0;
      bit v;
      while (n < num && guard < 1000) begin
         v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_valid = v;
         in_data  = v ? words[first+n] : DW'($urandom);
         if (v && in_ready) n++;
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b0;
      ok = (n == num);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; frame_ready = 1'b0; err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
      vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL reset_range_err: got %b expected 0", range_err); end
      vectors++; if (frame_data !== '0) begin miscompares++; $display("FAIL reset_buffer: got %h expected 0", frame_data); end
      rst = 1'b0;
      @(posedge clk); #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_ramp();
      bit ok;
      for (int k = 0; k < NW; k++) words[k] = DW'(k);
      frame_ready = 1'b1;
      fill(0, NW, 1'b0, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL ramp_fill_timeout: got %b expected 1", ok); end
      vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL ramp_frame_valid: got %b expected 1", frame_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ramp_in_ready: got %b expected 0", in_ready); end
      for (int k = 0; k < NW; k++) begin
         vectors++;
         if (word_at(k) !== CW'(37 * k)) begin miscompares++; $display("FAIL ramp_word%0d: got %0d expected %0d", k, word_at(k), 37 * k); end
      end
      @(posedge clk); #1;
      frame_ready = 1'b0;
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL ramp_taken_valid: got %b expected 0", frame_valid); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ramp_taken_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_range();
      bit ok;
      words[0] = DW'(7084);
      words[1] = DW'(7085);
      for (int k = 2; k < NW; k++) words[k] = DW'($urandom_range(0, MAXD));
      fill(0, 1, 1'b0, ok);
      vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL range_max_err: got %b expected 0", range_err); end
      fill(1, 1, 1'b0, ok);
      vectors++; if (range_err !== 1'b1) begin miscompares++; $display("FAIL range_over_err: got %b expected 1", range_err); end
      fill(2, NW - 2, 1'b1, ok);
      vectors++; if (!ok || frame_valid !== 1'b1) begin miscompares++; $display("FAIL range_frame: got ok=%b valid=%b expected 1", ok, frame_valid); end
      vectors++; if (word_at(0) !== 18'd262108) begin miscompares++; $display("FAIL range_word_max: got %0d expected 262108", word_at(0)); end
      vectors++; if (word_at(1) !== 18'd0) begin miscompares++; $display("FAIL range_word_over: got %0d expected 0", word_at(1)); end
      for (int k = 2; k < NW; k++) begin
         vectors++;
         if (word_at(k) !== ref_code(words[k])) begin miscompares++; $display("FAIL range_word%0d: got %0d expected %0d", k, word_at(k), ref_code(words[k])); end
      end
      vectors++; if (range_err !== 1'b1) begin miscompares++; $display("FAIL range_sticky: got %b expected 1", range_err); end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL range_clear: got %b expected 0", range_err); end
      frame_ready = 1'b1;
      @(posedge clk); #1;
      frame_ready = 1'b0;
      words[0] = DW'(7085);
      words[1] = DW'(7500);
      for (int k = 2; k < NW; k++) words[k] = DW'($urandom_range(0, MAXD));
      fill(0, 1, 1'b0, ok);
      err_clr = 1'b1;
      fill(1, 1, 1'b0, ok);
      err_clr = 1'b0;
      vectors++; if (range_err !== 1'b1) begin miscompares++; $display("FAIL range_priority: got %b expected 1", range_err); end
      fill(2, NW - 2, 1'b0, ok);
      vectors++; if (!ok || word_at(1) !== 18'd0 || word_at(0) !== 18'd0) begin miscompares++; $display("FAIL range_frame2: got w0=%0d w1=%0d ok=%b expected 0 0 1", word_at(0), word_at(1), ok); end
      err_clr = 1'b1; frame_ready = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0; frame_ready = 1'b0;
   endtask

   task automatic test_hold();
      bit ok;
      logic [NW*CW-1:0] exp_f;
      for (int k = 0; k < NW; k++) begin
         words[k] = DW'($urandom_range(0, MAXD));
         exp_f[k*CW +: CW] = ref_code(words[k]);
      end
      fill(0, NW, 1'b1, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL hold_fill_timeout: got %b expected 1", ok); end
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_data  = DW'($urandom);
         vectors++;
         if (frame_valid !== 1'b1 || in_ready !== 1'b0 || frame_data !== exp_f) begin
            miscompares++;
            $display("FAIL hold_cycle%0d: got valid=%b ready=%b data_ok=%b expected 1 0 1", c, frame_valid, in_ready, frame_data === exp_f);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; frame_ready = 1'b1;
      @(posedge clk); #1;
      frame_ready = 1'b0;
      vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release: got %b expected 0", frame_valid); end
      for (int k = 0; k < NW; k++) words[k] = DW'($urandom_range(0, MAXD));
      fill(0, NW, 1'b0, ok);
      vectors++; if (!ok || frame_valid !== 1'b1) begin miscompares++; $display("FAIL hold_next_frame: got ok=%b valid=%b expected 1 1", ok, frame_valid); end
      for (int k = 0; k < NW; k++) begin
         vectors++;
         if (word_at(k) !== ref_code(words[k])) begin miscompares++; $display("FAIL hold_next_word%0d: got %0d expected %0d", k, word_at(k), ref_code(words[k])); end
      end
      frame_ready = 1'b1;
      @(posedge clk); #1;
      frame_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      bit ok;
      for (int k = 0; k < NW; k++) words[k] = DW'($urandom_range(0, MAXD));
      fill(0, 20, 1'b1, ok);
      rst = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b0 || frame_valid !== 1'b0) begin miscompares++; $display("FAIL midfill_async: got ready=%b valid=%b expected 0 0", in_ready, frame_valid); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      vectors++; if (in_ready !== 1'b1 || frame_valid !== 1'b0) begin miscompares++; $display("FAIL midfill_release: got ready=%b valid=%b expected 1 0", in_ready, frame_valid); end
      for (int k = 0; k < NW; k++) words[k] = DW'($urandom_range(0, MAXD));
      fill(0, NW, 1'b1, ok);
      vectors++; if (!ok || frame_valid !== 1'b1) begin miscompares++; $display("FAIL midfill_frame: got ok=%b valid=%b expected 1 1", ok, frame_valid); end
      for (int k = 0; k < NW; k++) begin
         vectors++;
         if (word_at(k) !== ref_code(words[k])) begin miscompares++; $display("FAIL midfill_word%0d: got %0d expected %0d", k, word_at(k), ref_code(words[k])); end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      frame_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (frame_valid !== 1'b0 || frame_data !== '0) begin miscompares++; $display("FAIL midhold_discard%0d: got valid=%b data_zero=%b expected 0 1", c, frame_valid, frame_data === '0); end
      end
      frame_ready = 1'b0;
   endtask

   task automatic test_random_frames();
      bit ok;
      bit exp_err;
      for (int f = 0; f < 3; f++) begin
         err_clr = 1'b1;
         @(posedge clk); #1;
         err_clr = 1'b0;
         exp_err = 1'b0;
         for (int k = 0; k < NW; k++) begin
            words[k] = DW'($urandom_range(0, 8191));
            if (int'(words[k]) > MAXD) exp_err = 1'b1;
         end
         fill(0, NW, 1'b1, ok);
         vectors++; if (!ok || frame_valid !== 1'b1) begin miscompares++; $display("FAIL rand%0d_frame: got ok=%b valid=%b expected 1 1", f, ok, frame_valid); end
         vectors++; if (range_err !== exp_err) begin miscompares++; $display("FAIL rand%0d_range_err: got %b expected %b", f, range_err, exp_err); end
         for (int k = 0; k < NW; k++) begin
            vectors++;
            if (word_at(k) !== ref_code(words[k])) begin miscompares++; $display("FAIL rand%0d_word%0d: got %0d expected %0d", f, k, word_at(k), ref_code(words[k])); end
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         frame_ready = 1'b1;
         @(posedge clk); #1;
         frame_ready = 1'b0;
      end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] q [$];
      int rises [$];
      logic [DW-1:0] d;
      frame_ready = 1'b1;
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 200 && rises.size() < 3; cyc++) begin
         in_data = DW'($urandom_range(0, MAXD));
         if (frame_valid === 1'b1) begin
            rises.push_back(cyc);
            vectors++;
            if (q.size() != NW) begin miscompares++; $display("FAIL b2b_accepts: got %0d expected %0d", q.size(), NW); end
            for (int k = 0; k < NW && q.size() > 0; k++) begin
               d = q.pop_front();
               vectors++;
               if (word_at(k) !== ref_code(d)) begin miscompares++; $display("FAIL b2b_word%0d: got %0d expected %0d", k, word_at(k), ref_code(d)); end
            end
         end
         if (rises.size() < 3) begin
            if (in_ready === 1'b1) q.push_back(in_data);
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      frame_ready = 1'b0;
      vectors++; if (rises.size() != 3) begin miscompares++; $display("FAIL b2b_frames: got %0d expected 3", rises.size()); end
      for (int i = 1; i < rises.size(); i++) begin
         vectors++;
         if (rises[i] - rises[i-1] != 37) begin miscompares++; $display("FAIL b2b_period%0d: got %0d expected 37", i, rises[i] - rises[i-1]); end
      end
   endtask

`ifdef AN_ENC_ERR_INJ_EN
   task automatic test_inject();
      bit ok;
      for (int k = 0; k < NW; k++) words[k] = DW'(1);
      inj_en = 1'b1; inj_idx = 6'd0; inj_mask = 18'h1;
      fill(0, NW, 1'b0, ok);
      inj_en = 1'b0;
      vectors++; if (!ok || word_at(0) !== 18'd36) begin miscompares++; $display("FAIL inject_word0: got %0d expected 36", word_at(0)); end
      for (int k = 1; k < NW; k++) begin
         vectors++;
         if (word_at(k) !== 18'd37) begin miscompares++; $display("FAIL inject_word%0d: got %0d expected 37", k, word_at(k)); end
      end
      frame_ready = 1'b1;
      @(posedge clk); #1;
      frame_ready = 1'b0;
   endtask
`endif

   initial begin
`ifdef AN_ENC_ERR_INJ_EN
      inj_en = 1'b0; inj_idx = '0; inj_mask = '0;
`endif
      test_reset();
      test_ramp();
      test_range();
      test_hold();
      test_mid_reset();
      test_random_frames();
      test_back_to_back();
`ifdef AN_ENC_ERR_INJ_EN
      test_inject();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
